// File: rtl/tetris_pkg.sv
// tetris_pkg: shared state/move encodings, geometry constants and piece codes
package tetris_pkg;
  localparam int X_W = 5;
  localparam int Y_W = 5;
  localparam int SPAWN_X = 4;
  typedef enum logic [2:0] {S_IDLE, S_SPAWN, S_PLAY, S_CHECK, S_LOCK, S_OVER} state_t;
  typedef enum logic [2:0] {MK_SPAWN, MK_GRAV, MK_DOWN, MK_ROT, MK_LEFT, MK_RIGHT} kind_t;
  localparam logic [2:0] PC_I = 3'd0;
  localparam logic [2:0] PC_O = 3'd1;
  localparam logic [2:0] PC_T = 3'd2;
  localparam logic [2:0] PC_S = 3'd3;
  localparam logic [2:0] PC_Z = 3'd4;
  localparam logic [2:0] PC_J = 3'd5;
  localparam logic [2:0] PC_L = 3'd6;
endpackage

// File: rtl/move_arbiter.sv
// move_arbiter: priority select of one move event and its candidate pose
module move_arbiter
  import tetris_pkg::*;
#(
  parameter int X_W = tetris_pkg::X_W,
  parameter int Y_W = tetris_pkg::Y_W
) (
  input  logic                  tick,
  input  logic                  btn_down,
  input  logic                  btn_rot,
  input  logic                  btn_left,
  input  logic                  btn_right,
  input  logic signed [X_W-1:0] pos_x,
  input  logic        [Y_W-1:0] pos_y,
  input  logic        [1:0]     rot,
  output logic                  valid,
  output kind_t                 kind,
  output logic signed [X_W-1:0] cand_x,
  output logic        [Y_W-1:0] cand_y,
  output logic        [1:0]     cand_rot
);
  // gravity beats down beats rotate beats left beats right; x/y wrap and the checker rejects
  always_comb begin
    valid = tick | btn_down | btn_rot | btn_left | btn_right;
    kind = tick ? MK_GRAV : btn_down ? MK_DOWN : btn_rot ? MK_ROT : btn_left ? MK_LEFT : MK_RIGHT;
    cand_x = kind == MK_LEFT ? pos_x - X_W'(1) : kind == MK_RIGHT ? pos_x + X_W'(1) : pos_x;
    cand_y = (kind == MK_GRAV || kind == MK_DOWN) ? pos_y + Y_W'(1) : pos_y;
    cand_rot = kind == MK_ROT ? rot + 2'd1 : rot;
  end
endmodule

// File: rtl/piece_fall_ctrl.sv
// piece_fall_ctrl: active-piece FSM with collision-check and lock handshakes
module piece_fall_ctrl
  import tetris_pkg::*;
#(
  parameter int SPAWN_X = tetris_pkg::SPAWN_X,
  parameter int X_W = tetris_pkg::X_W,
  parameter int Y_W = tetris_pkg::Y_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  game_clk,
  input  logic                  btn_left,
  input  logic                  btn_right,
  input  logic                  btn_rot,
  input  logic                  btn_down,
  input  logic        [2:0]     piece_in,
  output logic                  ce,
  output logic        [2:0]     piece_type,
  output logic signed [X_W-1:0] pos_x,
  output logic        [Y_W-1:0] pos_y,
  output logic        [1:0]     rot,
  output logic                  chk_req,
  output logic signed [X_W-1:0] chk_x,
  output logic        [Y_W-1:0] chk_y,
  output logic        [1:0]     chk_rot,
  input  logic                  chk_ack,
  input  logic                  chk_ok,
  output logic                  lock_req,
  input  logic                  lock_ack,
  output logic                  game_over,
  output logic        [15:0]    pieces
);
  state_t state;
  kind_t kind, mv_kind;
  logic tick_pend, mv_valid;
  logic signed [X_W-1:0] mv_x;
  logic [Y_W-1:0] mv_y;
  logic [1:0] mv_rot;

  move_arbiter #(.X_W(X_W), .Y_W(Y_W)) u_arb (
    .tick(tick_pend | game_clk), .btn_down(btn_down), .btn_rot(btn_rot),
    .btn_left(btn_left), .btn_right(btn_right), .pos_x(pos_x), .pos_y(pos_y), .rot(rot),
    .valid(mv_valid), .kind(mv_kind), .cand_x(mv_x), .cand_y(mv_y), .cand_rot(mv_rot)
  );

  // game FSM; ce/chk_req/lock_req/game_over are registered alongside each transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      kind <= MK_SPAWN;
      tick_pend <= 1'b0;
      ce <= 1'b0;
      chk_req <= 1'b0;
      lock_req <= 1'b0;
      game_over <= 1'b0;
      piece_type <= '0;
      pos_x <= '0;
      pos_y <= '0;
      rot <= '0;
      chk_x <= '0;
      chk_y <= '0;
      chk_rot <= '0;
      pieces <= '0;
    end else begin
      if (game_clk && (state == S_SPAWN || state == S_CHECK || state == S_LOCK)) tick_pend <= 1'b1;
      case (state)
        S_IDLE: if (start) state <= S_SPAWN;
        S_SPAWN: begin
          piece_type <= piece_in;
          pos_x <= X_W'(SPAWN_X);
          pos_y <= '0;
          rot <= '0;
          chk_x <= X_W'(SPAWN_X);
          chk_y <= '0;
          chk_rot <= '0;
          kind <= MK_SPAWN;
          chk_req <= 1'b1;
          state <= S_CHECK;
        end
        S_PLAY: if (mv_valid) begin
          chk_x <= mv_x;
          chk_y <= mv_y;
          chk_rot <= mv_rot;
          kind <= mv_kind;
          chk_req <= 1'b1;
          ce <= 1'b0;
          state <= S_CHECK;
          if (mv_kind == MK_GRAV) tick_pend <= 1'b0;
        end
        S_CHECK: if (chk_ack) begin
          chk_req <= 1'b0;
          if (chk_ok) begin
            pos_x <= chk_x;
            pos_y <= chk_y;
            rot <= chk_rot;
            ce <= 1'b1;
            state <= S_PLAY;
          end else if (kind == MK_SPAWN) begin
            game_over <= 1'b1;
            state <= S_OVER;
          end else if (kind == MK_GRAV || kind == MK_DOWN) begin
            lock_req <= 1'b1;
            state <= S_LOCK;
          end else begin
            ce <= 1'b1;
            state <= S_PLAY;
          end
        end
        S_LOCK: if (lock_ack) begin
          lock_req <= 1'b0;
          pieces <= pieces + {15'd0, ~&pieces};
          state <= S_SPAWN;
        end
        S_OVER: if (start) begin
          pieces <= '0;
          game_over <= 1'b0;
          state <= S_SPAWN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_piece_fall_ctrl.sv
// tb_piece_fall_ctrl: directed scenarios with a scoreboard for check and lock requests
module tb_piece_fall_ctrl;
  import tetris_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, game_clk = 1'b0;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_rot = 1'b0, btn_down = 1'b0;
  logic [2:0] piece_in = '0;
  logic chk_ack = 1'b0, chk_ok = 1'b0, lock_ack = 1'b0;
  logic ce, chk_req, lock_req, game_over;
  logic [2:0] piece_type;
  logic signed [4:0] pos_x, chk_x;
  logic [4:0] pos_y, chk_y;
  logic [1:0] rot, chk_rot;
  logic [15:0] pieces;
  logic prev_chk = 1'b0, prev_lock = 1'b0;
  int n_chk = 0, n_fail = 0;
  logic [11:0] exp_chk[$], exp_lock[$];

  piece_fall_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .game_clk(game_clk),
    .btn_left(btn_left), .btn_right(btn_right), .btn_rot(btn_rot), .btn_down(btn_down),
    .piece_in(piece_in), .ce(ce), .piece_type(piece_type), .pos_x(pos_x), .pos_y(pos_y),
    .rot(rot), .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y), .chk_rot(chk_rot),
    .chk_ack(chk_ack), .chk_ok(chk_ok), .lock_req(lock_req), .lock_ack(lock_ack),
    .game_over(game_over), .pieces(pieces)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // scoreboard monitor: each new check/lock request is compared with the next expected pose
  always @(negedge clk) begin
    if (chk_req && !prev_chk) begin
      if (exp_chk.size() == 0) chk("unexpected_chk_req", 1, 0);
      else chk("chk_pose", {chk_x, chk_y, chk_rot}, exp_chk.pop_front());
    end
    if (lock_req && !prev_lock) begin
      if (exp_lock.size() == 0) chk("unexpected_lock_req", 1, 0);
      else chk("lock_pose", {pos_x, pos_y, rot}, exp_lock.pop_front());
    end
    prev_chk <= chk_req;
    prev_lock <= lock_req;
  end

  function automatic logic [11:0] pose(input int x, input int y, input int r);
    logic [4:0] xx = 5'(x);
    logic [4:0] yy = 5'(y);
    logic [1:0] rr = 2'(r);
    return {xx, yy, rr};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!chk_req && n < 50) begin
      step();
      n++;
    end
    if (!chk_req) chk("chk_req_timeout", 0, 1);
  endtask

  task automatic respond(input logic ok, input int lat);
    wait_req();
    repeat (lat) step();
    chk("req_held_at_ack", chk_req, 1);
    chk_ack = 1'b1;
    chk_ok = ok;
    step();
    chk_ack = 1'b0;
    chk_ok = 1'b0;
    chk("req_dropped_after_ack", chk_req, 0);
  endtask

  task automatic pulse(input int which);
    case (which)
      0: start = 1'b1;
      1: game_clk = 1'b1;
      2: btn_down = 1'b1;
      3: btn_rot = 1'b1;
      4: btn_left = 1'b1;
      5: btn_right = 1'b1;
      default: begin game_clk = 1'b1; btn_rot = 1'b1; btn_left = 1'b1; end
    endcase
    step();
    {start, game_clk, btn_down, btn_rot, btn_left, btn_right} = '0;
  endtask

  task automatic do_lock(input int lat);
    int n = 0;
    while (!lock_req && n < 50) begin
      step();
      n++;
    end
    chk("lock_req_high", lock_req, 1);
    repeat (lat) step();
    chk("lock_req_held", lock_req, 1);
    chk("ce_low_in_lock", ce, 0);
    lock_ack = 1'b1;
    step();
    lock_ack = 1'b0;
    chk("lock_req_dropped", lock_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_outputs", {ce, chk_req, lock_req, game_over}, 0);
    chk("rst_pose", {piece_type, pos_x, pos_y, rot}, 0);
    chk("rst_pieces", pieces, 0);
    rst_n = 1'b1;
    step();
    // spawn accepted with ack two cycles after the request
    piece_in = PC_S;
    exp_chk.push_back(pose(4, 0, 0));
    pulse(0);
    respond(1'b1, 2);
    chk("spawn_pose", {pos_x, pos_y, rot}, pose(4, 0, 0));
    chk("spawn_type", piece_type, 3);
    chk("play_ce", ce, 1);
    // gravity ok, then down rejected -> lock and respawn
    exp_chk.push_back(pose(4, 1, 0));
    pulse(1);
    chk("ce_low_in_check", ce, 0);
    respond(1'b1, 1);
    chk("grav_y", pos_y, 1);
    piece_in = PC_J;
    exp_chk.push_back(pose(4, 2, 0));
    exp_lock.push_back(pose(4, 1, 0));
    exp_chk.push_back(pose(4, 0, 0));
    pulse(2);
    respond(1'b0, 1);
    do_lock(3);
    chk("pieces_after_lock", pieces, 1);
    respond(1'b1, 0);
    chk("respawn_type", piece_type, 5);
    chk("respawn_pose", {pos_x, pos_y, rot}, pose(4, 0, 0));
    // simultaneous gravity, rotate and left: only gravity applies
    exp_chk.push_back(pose(4, 1, 0));
    pulse(6);
    respond(1'b1, 1);
    repeat (3) step();
    chk("prio_pose", {pos_x, pos_y, rot}, pose(4, 1, 0));
    chk("prio_no_extra_check", chk_req, 0);
    // tick during a left check is held and replayed
    exp_chk.push_back(pose(3, 1, 0));
    exp_chk.push_back(pose(3, 2, 0));
    pulse(4);
    pulse(1);
    respond(1'b1, 1);
    chk("left_x", pos_x, 32'(5'sd3));
    respond(1'b1, 0);
    chk("pend_y", pos_y, 2);
    // rotations, a rejected rotate, wrap back to zero, rejected left
    for (int i = 1; i <= 3; i++) begin
      exp_chk.push_back(pose(3, 2, i));
      pulse(3);
      respond(1'b1, 1);
    end
    exp_chk.push_back(pose(3, 2, 0));
    pulse(3);
    respond(1'b0, 1);
    chk("rot_after_reject", rot, 3);
    exp_chk.push_back(pose(3, 2, 0));
    pulse(3);
    respond(1'b1, 1);
    chk("rot_wrap", rot, 0);
    exp_chk.push_back(pose(2, 2, 0));
    pulse(4);
    respond(1'b0, 1);
    chk("left_reject_pose", {pos_x, pos_y, rot}, pose(3, 2, 0));
    chk("left_reject_no_lock", lock_req, 0);
    chk("left_reject_ce", ce, 1);
    exp_chk.push_back(pose(4, 2, 0));
    pulse(5);
    respond(1'b1, 2);
    chk("right_x", pos_x, 32'(5'sd4));
    // lock again, then spawn collision -> game over
    exp_chk.push_back(pose(4, 3, 0));
    exp_lock.push_back(pose(4, 2, 0));
    exp_chk.push_back(pose(4, 0, 0));
    piece_in = PC_O;
    pulse(2);
    respond(1'b0, 0);
    do_lock(1);
    chk("pieces_two", pieces, 2);
    respond(1'b0, 1);
    chk("game_over_set", game_over, 1);
    chk("over_ce", ce, 0);
    pulse(4);
    repeat (2) step();
    chk("over_ignores_buttons", chk_req, 0);
    // restart clears the counter; reset mid-check drops the request
    exp_chk.push_back(pose(4, 0, 0));
    pulse(0);
    chk("restart_pieces", pieces, 0);
    chk("restart_game_over", game_over, 0);
    wait_req();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_chk_req", chk_req, 0);
    chk("async_rst_pose", {pos_x, pos_y, rot}, 0);
    step();
    rst_n = 1'b1;
    chk_ack = 1'b1;
    chk_ok = 1'b1;
    step();
    chk_ack = 1'b0;
    chk_ok = 1'b0;
    repeat (2) step();
    chk("late_ack_ignored", {ce, chk_req, pos_x}, 0);
    chk("chk_queue_empty", exp_chk.size(), 0);
    chk("lock_queue_empty", exp_lock.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
